mips_data_bridge: RTL and testbench

MIPS_DATA_BRIDGE -- requirements
Module: mips_data_bridge

---
 rtl/mips_data_bridge.sv | 157 +++++++++++++++
 tb/tb_mips_data_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_bridge.sv
// -----------------------------------------------------------------------------
// mips_data_bridge
// Bridges the single-cycle-style MIPS CPU data port onto a waitrequest-based
// memory bus. The CPU is held via cpu_stall while one bus access is in flight;
// loads return through a read register that only changes when an access ends.
//
// Ports
//   clk             : single clock, all state updates on the rising edge
//   reset           : asynchronous, active-low reset
//   cpu_address     : CPU byte address (must be word aligned)
//   cpu_read        : CPU load request
//   cpu_write       : CPU store request (wins over cpu_read)
//   cpu_writedata   : CPU store data
//   cpu_readdata    : load data, the read register (holds between accesses)
//   cpu_stall       : high while the CPU must hold its request
//   mem_address     : word-aligned bus address
//   mem_read        : bus read strobe
//   mem_write       : bus write strobe
//   mem_writedata   : bus write data
//   mem_byteenable  : 4'b1111 while a strobe is high, else 4'b0000
//   mem_waitrequest : high while the bus has not accepted/completed the access
//   mem_readdata    : bus read data, valid when waitrequest is low in a read
//   fault           : sticky error (misaligned, read+write conflict, timeout)
//   state_dbg       : current FSM state (IDLE=0, READ=1, WRITE=2, DONE=3)
//
// Handshake: a CPU request is accepted in IDLE on the edge where cpu_read or
// cpu_write is high; cpu_stall is high combinationally in that cycle and in
// READ/WRITE, and low in DONE, which is the cycle the CPU may advance. On the
// bus, a strobe completes on the first edge where it is high and
// mem_waitrequest is low; address, data and strobe stay constant until then.
//
// MAX_WAIT must be at least 1: the access is aborted on the MAX_WAIT-th
// consecutive cycle in which the strobe is high and waitrequest is high.
// -----------------------------------------------------------------------------
module mips_data_bridge #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_stall,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        fault,
    output logic [1:0]  state_dbg
);

    // Wait counter is at least 8 bits and wide enough to hold MAX_WAIT.
    localparam int CW = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   read_reg;
    logic          request;

    assign request      = cpu_read | cpu_write;
    assign cpu_readdata = read_reg;
    assign state_dbg    = state;

    // The stall must rise in the very cycle the request appears, so in IDLE it
    // follows the request combinationally; elsewhere it depends on state only.
    always_comb begin
        cpu_stall = 1'b0;
        case (state)
            IDLE:        cpu_stall = request;
            READ, WRITE: cpu_stall = 1'b1;
            default:     cpu_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            read_reg       <= 32'h0;
            fault          <= 1'b0;
            mem_address    <= 32'h0;
            mem_writedata  <= 32'h0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_byteenable <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        mem_address   <= {cpu_address[31:2], 2'b00};
                        mem_writedata <= cpu_writedata;
                        wait_cnt      <= '0;
                        if (cpu_read && cpu_write) begin
                            fault <= 1'b1;
                        end
                        if (cpu_address[1:0] != 2'b00) begin
                            // Misaligned: never reaches the bus, load returns 0.
                            fault    <= 1'b1;
                            read_reg <= 32'h0;
                            state    <= DONE;
                        end else if (cpu_write) begin
                            mem_write      <= 1'b1;
                            mem_byteenable <= 4'b1111;
                            state          <= WRITE;
                        end else begin
                            mem_read       <= 1'b1;
                            mem_byteenable <= 4'b1111;
                            state          <= READ;
                        end
                    end
                end
                READ, WRITE: begin
                    if (!mem_waitrequest) begin
                        if (state == READ) begin
                            read_reg <= mem_readdata;
                        end
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_byteenable <= 4'b0000;
                        state          <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        // Bus never answered: give up and report through fault.
                        wait_cnt       <= wait_cnt + 1'b1;
                        fault          <= 1'b1;
                        read_reg       <= 32'h0;
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_byteenable <= 4'b0000;
                        state          <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_data_bridge.sv
// -----------------------------------------------------------------------------
// tb_mips_data_bridge
// Self-checking bench for mips_data_bridge (MAX_WAIT = 4). A CPU driver task
// issues one access at a time and also plays the bus slave with a chosen
// number of wait cycles. The expected load data is pushed to exp_q when the
// access is driven and popped when the bridge releases the stall.
// -----------------------------------------------------------------------------
module tb_mips_data_bridge;

    localparam int MAX_WAIT = 4;

    // ---------------------------------------------------------------- signals
    logic        clk;
    logic        reset;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_stall;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        fault;
    logic [1:0]  state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: last value the read register should hold, sticky fault.
    logic [31:0] last_rd;
    logic        fault_m;
    logic [31:0] exp_q[$];

    mips_data_bridge #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_address     (cpu_address),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_writedata   (cpu_writedata),
        .cpu_readdata    (cpu_readdata),
        .cpu_stall       (cpu_stall),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .fault           (fault),
        .state_dbg       (state_dbg)
    );

    // ------------------------------------------------------- clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------- checking
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Checks everything the reset must clear; called while reset is low.
    task automatic check_reset_values();
        check_eq("rst_mem_read",   {31'b0, mem_read},  32'h0);
        check_eq("rst_mem_write",  {31'b0, mem_write}, 32'h0);
        check_eq("rst_byteenable", {28'b0, mem_byteenable}, 32'h0);
        check_eq("rst_mem_address", mem_address, 32'h0);
        check_eq("rst_mem_wdata",  mem_writedata, 32'h0);
        check_eq("rst_readdata",   cpu_readdata, 32'h0);
        check_eq("rst_fault",      {31'b0, fault}, 32'h0);
        check_eq("rst_state",      {30'b0, state_dbg}, 32'h0);
    endtask

    // --------------------------------------------------------------- drivers
    task automatic apply_reset();
        @(negedge clk);
        reset           = 1'b0;
        cpu_read        = 1'b0;
        cpu_write       = 1'b0;
        mem_waitrequest = 1'b1;
        last_rd         = 32'h0;
        fault_m         = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values();
        check_eq("rst_stall", {31'b0, cpu_stall}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One CPU access, called at a falling edge. The bench also answers as the
    // bus slave: waitrequest stays high for 'waits' strobe cycles, then low.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int waits,
                             input logic [31:0] rdata);
        int          stall_cycles;
        int          strobe_cycles;
        int          seen_wait;
        int          exp_strobe;
        int          exp_stall;
        logic        misaligned;
        logic        timeout;
        logic        done;
        logic [31:0] exp_rd;

        misaligned = (addr[1:0] != 2'b00);
        timeout    = !misaligned && (waits >= MAX_WAIT);
        if (misaligned) begin
            exp_strobe = 0;
            exp_stall  = 1;
        end else if (timeout) begin
            exp_strobe = MAX_WAIT;
            exp_stall  = 1 + MAX_WAIT;
        end else begin
            exp_strobe = waits + 1;
            exp_stall  = waits + 2;
        end
        if (misaligned || timeout) last_rd = 32'h0;
        else if (!wr)              last_rd = rdata;
        if (misaligned || timeout || (rd && wr)) fault_m = 1'b1;
        exp_q.push_back(last_rd);

        cpu_read        = rd;
        cpu_write       = wr;
        cpu_address     = addr;
        cpu_writedata   = wdata;
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'hDEAD_BEEF;
        stall_cycles    = 0;
        strobe_cycles   = 0;
        seen_wait       = 0;
        done            = 1'b0;

        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (mem_read || mem_write) begin
                strobe_cycles++;
                check_eq("strobe_kind", {30'b0, mem_write, mem_read}, {30'b0, wr, rd && !wr});
                check_eq("bus_address", mem_address, {addr[31:2], 2'b00});
                check_eq("bus_wdata", mem_writedata, wdata);
                check_eq("byteenable", {28'b0, mem_byteenable}, 32'hF);
                if (seen_wait < waits) begin
                    mem_waitrequest = 1'b1;
                    mem_readdata    = 32'hDEAD_BEEF;
                    seen_wait++;
                end else begin
                    mem_waitrequest = 1'b0;
                    mem_readdata    = rdata;
                end
            end
            if (cpu_stall) begin
                stall_cycles++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end

        check_eq("access_completed", {31'b0, done}, 32'h1);
        exp_rd = exp_q.pop_front();
        check_eq("readdata", cpu_readdata, exp_rd);
        check_eq("fault", {31'b0, fault}, {31'b0, fault_m});
        check_eq("strobe_cycles", 32'(strobe_cycles), 32'(exp_strobe));
        check_eq("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
        check_eq("done_byteenable", {28'b0, mem_byteenable}, 32'h0);

        // CPU advances at the edge that ends the non-stalled cycle.
        cpu_read        = 1'b0;
        cpu_write       = 1'b0;
        mem_waitrequest = 1'b1;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        logic        r_wr;
        logic [31:0] r_addr;

        reset           = 1'b0;
        cpu_address     = 32'h0;
        cpu_read        = 1'b0;
        cpu_write       = 1'b0;
        cpu_writedata   = 32'h0;
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'h0;
        last_rd         = 32'h0;
        fault_m         = 1'b0;

        apply_reset();

        // Zero-wait read: stall 1,1,0 and data returned in DONE.
        do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hCAFE_F00D);
        // Write with three wait cycles: strobe held four cycles, no fault.
        do_access(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 3, 32'h0);
        // Back-to-back accesses with random aligned addresses and waits.
        for (int i = 0; i < 8; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = $urandom() & 32'hFFFF_FFFC;
            do_access(!r_wr, r_wr, r_addr, $urandom(), $urandom_range(0, 3), $urandom());
        end

        // Misaligned read: no bus strobe, load returns 0, fault set.
        do_access(1'b1, 1'b0, 32'h0000_0102, 32'h0, 0, 32'h5555_AAAA);
        // Fault is sticky across a following clean read.
        do_access(1'b1, 1'b0, 32'h0000_0108, 32'h0, 1, 32'h0BAD_CAFE);

        // Reset during a write wait state drops the strobe immediately.
        cpu_write       = 1'b1;
        cpu_address     = 32'h0000_0400;
        cpu_writedata   = 32'hA5A5_5A5A;
        mem_waitrequest = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("pre_rst_write", {31'b0, mem_write}, 32'h1);
        reset = 1'b0;
        #1;
        check_reset_values();
        last_rd = 32'h0;
        fault_m = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("no_resume_write", {31'b0, mem_write}, 32'h0);
        check_eq("no_resume_stall", {31'b0, cpu_stall}, 32'h0);
        @(negedge clk);

        // Read with waitrequest stuck high: timeout after MAX_WAIT cycles.
        do_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 50, 32'h7777_7777);
        #1;
        check_eq("timeout_idle", {30'b0, state_dbg}, 32'h0);
        @(negedge clk);

        // Read and write together: proceeds as a write, fault set.
        apply_reset();
        do_access(1'b1, 1'b1, 32'h0000_0300, 32'hFEED_BEEF, 1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
